// File: rtl/md_pkg.sv
// Shared M-extension definitions: funct3 codes, dispatch FSM states, divide constants.
package md_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RD_W = 5;
  localparam int unsigned F3_W = 3;

  localparam logic [F3_W-1:0] F3_DIV  = 3'b100;
  localparam logic [F3_W-1:0] F3_DIVU = 3'b101;
  localparam logic [F3_W-1:0] F3_REM  = 3'b110;
  localparam logic [F3_W-1:0] F3_REMU = 3'b111;

  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } md_state_e;

  // Identity of a divide operation; the memo is keyed on the full tuple.
  typedef struct packed {
    logic [F3_W-1:0] funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } md_tag_t;

endpackage

// File: rtl/md_div_fastpath.sv
// Combinational classifier for divides that can be answered without the divider.
module md_div_fastpath
  import md_pkg::*;
(
  input  logic [F3_W-1:0] i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  md_tag_t         i_memo_tag,
  input  logic [XLEN-1:0] i_memo_result,
  input  logic            i_memo_valid,
  output logic            o_hit,
  output logic [XLEN-1:0] o_value
);

  logic    w_is_rem;
  logic    w_is_signed;
  md_tag_t w_tag;

  assign w_is_rem    = i_funct3[1];
  assign w_is_signed = ~i_funct3[0];
  assign w_tag       = '{funct3: i_funct3, rs1: i_rs1, rs2: i_rs2};

  // Checks are ordered: divide-by-zero, signed overflow, unit divisor, memo.
  always_comb begin
    o_hit   = 1'b0;
    o_value = '0;
    if (i_rs2 == '0) begin
      o_hit   = 1'b1;
      o_value = w_is_rem ? i_rs1 : ALL_ONES;
    end else if (w_is_signed && (i_rs1 == INT_MIN) && (i_rs2 == ALL_ONES)) begin
      o_hit   = 1'b1;
      o_value = w_is_rem ? '0 : INT_MIN;
    end else if (i_rs2 == XLEN'(1)) begin
      o_hit   = 1'b1;
      o_value = w_is_rem ? '0 : i_rs1;
    end else if (i_memo_valid && (i_memo_tag == w_tag)) begin
      o_hit   = 1'b1;
      o_value = i_memo_result;
    end
  end

endmodule

// File: rtl/md_div_dispatch.sv
// Feeds the iterative divider from EX, short-circuits trivial divides and
// collects the divider result into a registered write-back pulse.
module md_div_dispatch
  import md_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_ex_valid,
  input  logic            i_ex_md_type,
  input  logic [F3_W-1:0] i_ex_funct3,
  input  logic [XLEN-1:0] i_ex_rs1,
  input  logic [XLEN-1:0] i_ex_rs2,
  input  logic [RD_W-1:0] i_ex_rd,
  input  logic            i_flush,
  output logic            o_div_start,
  output logic [F3_W-1:0] o_div_op,
  output logic [XLEN-1:0] o_div_a,
  output logic [XLEN-1:0] o_div_b,
  input  logic [XLEN-1:0] i_div_result,
  input  logic            i_div_stall,
  input  logic            i_div_done,
  output logic            o_md_stall,
  output logic            o_wb_valid,
  output logic [RD_W-1:0] o_wb_rd,
  output logic [XLEN-1:0] o_wb_data
);

  md_state_e       r_state;
  logic            r_memo_valid;
  md_tag_t         r_memo_tag;
  logic [XLEN-1:0] r_memo_result;
  md_tag_t         r_tag;
  logic [RD_W-1:0] r_rd;
  logic            r_wb_valid;
  logic [RD_W-1:0] r_wb_rd;
  logic [XLEN-1:0] r_wb_data;

  logic            w_req;
  logic            w_hit;
  logic [XLEN-1:0] w_value;
  logic            w_launch;

  assign w_req    = i_ex_valid & i_ex_md_type & i_ex_funct3[2] & ~i_flush;
  assign w_launch = (r_state == IDLE) & w_req & ~w_hit;

  md_div_fastpath u_fastpath (
    .i_funct3      (i_ex_funct3),
    .i_rs1         (i_ex_rs1),
    .i_rs2         (i_ex_rs2),
    .i_memo_tag    (r_memo_tag),
    .i_memo_result (r_memo_result),
    .i_memo_valid  (r_memo_valid),
    .o_hit         (w_hit),
    .o_value       (w_value)
  );

  // Divider operands are only driven during the launch cycle.
  assign o_div_start = w_launch;
  assign o_div_op    = w_launch ? i_ex_funct3 : '0;
  assign o_div_a     = w_launch ? i_ex_rs1    : '0;
  assign o_div_b     = w_launch ? i_ex_rs2    : '0;

  always_comb begin
    o_md_stall = 1'b0;
    case (r_state)
      IDLE:    o_md_stall = w_req & ~w_hit;
      WAIT:    o_md_stall = 1'b1;
      RESP:    o_md_stall = 1'b0;
      DRAIN:   o_md_stall = w_req;
      default: o_md_stall = 1'b0;
    endcase
  end

  assign o_wb_valid = r_wb_valid;
  assign o_wb_rd    = r_wb_rd;
  assign o_wb_data  = r_wb_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_memo_valid  <= 1'b0;
      r_memo_tag    <= '0;
      r_memo_result <= '0;
      r_tag         <= '0;
      r_rd          <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_data     <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req && w_hit) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= i_ex_rd;
            r_wb_data  <= w_value;
          end else if (w_req) begin
            r_tag   <= '{funct3: i_ex_funct3, rs1: i_ex_rs1, rs2: i_ex_rs2};
            r_rd    <= i_ex_rd;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (i_div_done) begin
            r_memo_valid  <= 1'b1;
            r_memo_tag    <= r_tag;
            r_memo_result <= i_div_result;
            if (i_flush) begin
              r_state <= IDLE;
            end else begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= i_div_result;
              r_state    <= RESP;
            end
          end else if (i_flush) begin
            r_state <= DRAIN;
          end
        end
        RESP: r_state <= IDLE;
        DRAIN: begin
          // A killed op still finishes; keep its result for reuse.
          if (i_div_done) begin
            r_memo_valid  <= 1'b1;
            r_memo_tag    <= r_tag;
            r_memo_result <= i_div_result;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The divider must report busy for every WAIT cycle before it finishes.
  a_div_busy_in_wait: assert property (@(posedge clk) disable iff (reset)
    ((r_state == WAIT) && !i_div_done) |-> i_div_stall);

endmodule
